// File: rtl/fifo_read_ctrl_rr_if.sv
// Handshake bundle between the round-robin FIFO read controller, its per-channel
// FIFOs and the shared downstream consumer.
interface fifo_read_ctrl_rr_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 4,
    parameter int BURST_MAX = 16
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int BL_W = $clog2(BURST_MAX + 1);

    logic                     i_ren;
    logic [BL_W-1:0]          i_burst_len;
    logic [NUM_CH-1:0]        i_empty;
    logic [NUM_CH-1:0]        i_aempty;
    logic [NUM_CH*DATA_W-1:0] i_rdata;
    logic                     i_ready;

    logic [NUM_CH-1:0]        o_ren;
    logic [DATA_W-1:0]        o_data;
    logic                     o_valid;
    logic [CH_W-1:0]          o_ch;
    logic                     o_last;
    logic [NUM_CH-1:0]        o_grant;
    logic                     o_busy;

    modport slave (
        input  i_ren, i_burst_len, i_empty, i_aempty, i_rdata, i_ready,
        output o_ren, o_data, o_valid, o_ch, o_last, o_grant, o_busy
    );

    modport master (
        output i_ren, i_burst_len, i_empty, i_aempty, i_rdata, i_ready,
        input  o_ren, o_data, o_valid, o_ch, o_last, o_grant, o_busy
    );
endinterface

// File: rtl/fifo_read_ctrl_rr.sv
// Round-robin burst reader over NUM_CH FWFT FIFOs onto one registered valid/ready stream.
// state | meaning
// IDLE  | no grant; searches for the next non-empty channel after rr_ptr
// BURST | popping up to the sampled burst length from the granted channel
module fifo_read_ctrl_rr #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 4,
    parameter int BURST_MAX = 16
) (
    input  logic               i_clk,
    input  logic               i_rest,
    fifo_read_ctrl_rr_if.slave bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int BL_W = $clog2(BURST_MAX + 1);

    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_BURST = 1'b1;
    localparam logic [CH_W-1:0] PTR_RST  = CH_W'(NUM_CH - 1);
    localparam logic [BL_W-1:0] LEN_MAX  = BL_W'(BURST_MAX);
    localparam logic [BL_W-1:0] LEN_ONE  = BL_W'(1);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   gidx_q, gidx_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [BL_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              last_q, last_d;

    logic              arb_found;
    logic [CH_W-1:0]   arb_pick;
    int                arb_idx;
    logic [BL_W-1:0]   len_clamped;
    logic              in_burst;
    logic              slot_free;
    logic              pop;
    logic              last_beat;
    logic [DATA_W-1:0] head_word;

    // Search starts one past the last served channel so it ends up lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_idx   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            arb_idx = (int'(rr_ptr_q) + i) % NUM_CH;
            if (!arb_found && !bus.i_empty[arb_idx]) begin
                arb_found = 1'b1;
                arb_pick  = CH_W'(arb_idx);
            end
        end
    end

    always_comb begin
        if (bus.i_burst_len == '0) begin
            len_clamped = LEN_ONE;
        end else if (bus.i_burst_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end else begin
            len_clamped = bus.i_burst_len;
        end
    end

    assign in_burst  = (state_q == ST_BURST);
    assign slot_free = ~valid_q | bus.i_ready;
    assign pop       = in_burst & bus.i_ren & ~bus.i_empty[gidx_q] & slot_free;
    assign last_beat = (rem_q == LEN_ONE) | bus.i_aempty[gidx_q];
    assign head_word = bus.i_rdata[gidx_q*DATA_W +: DATA_W];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        rem_d    = rem_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ch_d     = ch_q;
        last_d   = last_q;

        if (state_q == ST_IDLE) begin
            if (bus.i_ren && arb_found) begin
                state_d = ST_BURST;
                gidx_d  = arb_pick;
                grant_d = ONE_HOT0 << arb_pick;
                rem_d   = len_clamped;
            end
        end else begin
            if (pop) begin
                rem_d = rem_q - LEN_ONE;
                if (last_beat) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = gidx_q;
                    grant_d  = '0;
                end
            end else if (bus.i_ren && bus.i_empty[gidx_q] && slot_free) begin
                // Channel ran dry without an almost-empty warning: drop the grant.
                state_d  = ST_IDLE;
                rr_ptr_d = gidx_q;
                grant_d  = '0;
            end
        end

        if (pop) begin
            data_d  = head_word;
            ch_d    = gidx_q;
            valid_d = 1'b1;
            last_d  = last_beat;
        end else if (bus.i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rest) begin
        if (i_rest) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= PTR_RST;
            gidx_q   <= '0;
            grant_q  <= '0;
            rem_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ch_q     <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ch_q     <= ch_d;
            last_q   <= last_d;
        end
    end

    assign bus.o_ren   = pop ? grant_q : '0;
    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_ch    = ch_q;
    assign bus.o_last  = last_q;
    assign bus.o_grant = grant_q;
    assign bus.o_busy  = in_burst;
endmodule

// File: doc/fifo_read_ctrl_rr.md
# fifo_read_ctrl_rr

Parametrised multi-channel successor to the single-FIFO read controller. It arbitrates round-robin among NUM_CH first-word-fall-through FIFOs and pops a bounded burst from the granted channel. It drives the popped words onto one registered valid/ready output stream, tagged with channel index and end-of-burst. It sits between the per-channel ingress FIFOs and the shared downstream consumer.

## Interface
- DATA_W, 8, width of each FIFO word.
- NUM_CH, 4, number of FIFO channels (2..16).
- BURST_MAX, 16, maximum words per grant.
- CH_W, $clog2(NUM_CH), channel index width (derived).
- BL_W, $clog2(BURST_MAX+1), burst length field width (derived).

- i_clk  in  1  clock; all logic on rising edge.
- i_rest  in  1  asynchronous, active-high reset.
- i_ren  in  1  global read enable; low pauses all pops.
- i_burst_len  in  BL_W  requested burst length, sampled at grant.
- i_empty  in  NUM_CH  per-channel FIFO empty.
- i_aempty  in  NUM_CH  per-channel "exactly one word held".
- i_rdata  in  NUM_CH*DATA_W  per-channel FWFT head word; channel k at bits [k*DATA_W +: DATA_W].
- i_ready  in  1  downstream accepts o_data this cycle.
- o_ren  out  NUM_CH  one-hot combinational pop strobe to the FIFOs.
- o_data  out  DATA_W  registered output word.
- o_valid  out  1  o_data valid.
- o_ch  out  CH_W  source channel of o_data.
- o_last  out  1  o_data is final beat of its burst.
- o_grant  out  NUM_CH  registered one-hot current grant; 0 when idle.
- o_busy  out  1  high in BURST state.

## Operation
- Reset values: o_valid=0, o_data=0, o_ch=0, o_last=0, o_grant=0, o_busy=0, o_ren=0. State IDLE, rr_ptr=NUM_CH-1, remaining=0.
- Burst length: i_burst_len=0 treated as 1; values >BURST_MAX clamped to BURST_MAX.
- IDLE: if i_ren=1 and any i_empty bit is 0, grant the first non-empty channel searching rr_ptr+1, rr_ptr+2, ... with wrap. Register the grant, load remaining from i_burst_len and go to BURST. No pop occurs in the grant cycle.
- BURST, granted channel g:
  - pop = i_ren & ~i_empty[g] & (~o_valid | i_ready).
  - o_ren[g] = pop. All other o_ren bits stay 0.
- On pop:
  - o_data <= i_rdata slice g, o_ch <= g, o_valid <= 1.
  - o_last <= (remaining==1) | i_aempty[g].
  - remaining decrements.
  - If o_last is being set: state <= IDLE, rr_ptr <= g, o_grant <= 0.
- Empty handling:
  - i_empty[g]=1 in BURST with no pop, while i_ren=1 and the output slot is free: burst aborts, state <= IDLE, rr_ptr <= g.
  - No beat is emitted on abort. The previous beat's o_last is not retro-asserted.
- i_ren=0 in BURST: hold state, grant and remaining. No pops.
- Output handshake:
  - o_valid is cleared when i_ready=1 and no pop occurs that cycle.
  - While o_valid=1 and i_ready=0, o_data, o_ch and o_last are held stable.
- Fairness: after channel g's burst, g has lowest priority for the next grant.
- Reset asserted mid-burst: all state and outputs return to reset values immediately and asynchronously. The in-progress burst is discarded.

## Timing
- Grant latency: IDLE with request at cycle t → o_grant/o_busy high at t+1, first pop at t+1.
- Pop to output: pop in cycle t → o_valid with that word from t+1.
- Throughput: one word per cycle within a burst when i_ready=1 continuously.
- Inter-burst gap: exactly one idle cycle (the grant cycle) between the last pop of one burst and the first pop of the next.
- o_ren is combinational from i_empty, i_ren, i_ready, o_valid and the registered state. It has no path from i_rdata.

## Test plan
- Single channel: ch1 holds 5 words (A1..A5), i_burst_len=4, i_ready=1 → grant ch1 next cycle; beats A1..A4 on consecutive cycles, o_ch=1, o_last only on A4. One idle cycle, then A5 with o_last=1 (i_aempty).
- Round-robin: all 4 channels non-empty, burst_len=2 → grant order 0,1,2,3,0. Each burst is 2 beats with o_last on the 2nd.
- Backpressure: i_ready=0 for 3 cycles mid-burst → o_data/o_ch/o_last held. At most one extra pop, issued only when the slot frees. No word lost or duplicated.
- Early empty: burst_len=8, channel holds 3 words, i_aempty set on the 3rd → 3 beats, o_last on the 3rd, return to IDLE.
- Clamp and pause: i_burst_len=0 → 1-beat burst. i_burst_len=31 with BURST_MAX=16 → 16 beats. i_ren=0 for 2 cycles mid-burst → no o_ren, burst resumes with the count intact.
- Async reset mid-burst → all outputs 0 within the same cycle, o_ren=0. After release, the next grant goes to channel 0 if it is non-empty.
